// File: rtl/lz77_sched_pkg.sv
// lz77_sched_pkg: shared state encoding and token field widths for the LZ77 job scheduler
package lz77_sched_pkg;
    typedef enum logic [2:0] {IDLE, ERST, LOAD, RUN, DONE} state_t;
    localparam int OFF_W = 4;
    localparam int LEN_W = 3;
    localparam int CHR_W = 8;
    localparam int TOK_W = OFF_W + LEN_W + CHR_W;
    localparam int JOB_LEN = 2048;
    localparam logic [CHR_W-1:0] END_CHAR = 8'h24;
endpackage

// File: rtl/lz77_tok_fifo.sv
// lz77_tok_fifo: first-word fall-through FIFO that drops and flags pushes arriving while full
module lz77_tok_fifo #(
    parameter int W = 17,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop_req,
    output logic [W-1:0] data,
    output logic         empty,
    output logic         full,
    output logic         drop
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic pop, wr_en;
    assign empty = wr_ptr == rd_ptr;
    assign full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    assign data = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign pop = !empty && pop_req;
    // a pop frees the slot the same cycle, so a full FIFO can still accept
    assign wr_en = push && (!full || pop);
    assign drop = push && full && !pop;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    always_ff @(posedge clk)
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
endmodule

// File: rtl/lz77_job_scheduler.sv
// lz77_job_scheduler: round-robin sharing of one LZ77 encoder, streaming job chars in and
// collecting owner-tagged tokens into a backpressured FIFO
module lz77_job_scheduler
    import lz77_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW = 1,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT = 131072
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    output logic [NREQ-1:0]      grant,
    input  logic [NREQ-1:0]      in_valid,
    input  logic [8*NREQ-1:0]    in_data,
    output logic [NREQ-1:0]      in_ready,
    output logic                 enc_rst,
    output logic [CHR_W-1:0]     enc_chardata,
    input  logic                 enc_valid,
    input  logic                 enc_finish,
    input  logic [OFF_W-1:0]     enc_offset,
    input  logic [LEN_W-1:0]     enc_match_len,
    input  logic [CHR_W-1:0]     enc_char_nxt,
    output logic                 tok_valid,
    input  logic                 tok_ready,
    output logic [TOK_W-1:0]     tok_data,
    output logic [IDW-1:0]       tok_id,
    output logic                 tok_last,
    output logic [NREQ-1:0]      job_done,
    output logic                 busy,
    output logic                 err_underrun,
    output logic                 err_overflow,
    output logic                 err_timeout,
    input  logic                 err_clr
);
    localparam int RCW = $clog2(TIMEOUT + 1);
    localparam int FW = TOK_W + IDW + 1;
    state_t state, state_n;
    logic [IDW-1:0] owner, pick, idx, rr_ptr;
    logic [NREQ-1:0] own_oh;
    logic found, timeout_hit, push, drop, empty, full;
    logic [10:0] load_cnt;
    logic [RCW-1:0] run_cnt;
    logic [FW-1:0] fifo_out;
    // scan downward so the requester closest after rr_ptr is the last one written
    always_comb begin
        pick = '0;
        idx = '0;
        found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IDW'((int'(rr_ptr) + k) % NREQ);
            if (req[idx]) begin
                pick = idx;
                found = 1'b1;
            end
        end
    end
    assign own_oh = NREQ'(1) << owner;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state;
        grant = '0;
        in_ready = '0;
        enc_rst = 1'b1;
        enc_chardata = '0;
        job_done = '0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: state_n = found ? ERST : IDLE;
            ERST: begin
                grant = own_oh;
                state_n = LOAD;
            end
            LOAD: begin
                grant = own_oh;
                in_ready = own_oh;
                enc_rst = 1'b0;
                enc_chardata = in_valid[owner] ? in_data[{owner, 3'b000} +: 8] : 8'h00;
                state_n = load_cnt == 11'(JOB_LEN - 1) ? RUN : LOAD;
            end
            RUN: begin
                grant = own_oh;
                enc_rst = 1'b0;
                timeout_hit = !enc_finish && run_cnt == RCW'(TIMEOUT - 1);
                state_n = (enc_finish || timeout_hit) ? DONE : RUN;
            end
            DONE: begin
                job_done = own_oh;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            owner <= '0;
            rr_ptr <= '0;
            load_cnt <= '0;
            run_cnt <= '0;
            err_underrun <= 1'b0;
            err_overflow <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (state == IDLE && found) begin
                owner <= pick;
                rr_ptr <= IDW'((int'(pick) + 1) % NREQ);
            end
            load_cnt <= state == LOAD ? load_cnt + 11'd1 : 11'd0;
            run_cnt <= state == RUN ? run_cnt + RCW'(1) : '0;
            err_underrun <= !err_clr && (err_underrun || (state == LOAD && !in_valid[owner]));
            err_overflow <= !err_clr && (err_overflow || drop);
            err_timeout <= !err_clr && (err_timeout || timeout_hit);
        end
    assign push = state == RUN && enc_valid;
    lz77_tok_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(push),
        .push_data({enc_offset, enc_match_len, enc_char_nxt, owner, enc_char_nxt == END_CHAR}),
        .pop_req(tok_ready),
        .data(fifo_out),
        .empty(empty),
        .full(full),
        .drop(drop)
    );
    assign tok_valid = !empty;
    assign tok_data = fifo_out[FW-1 -: TOK_W];
    assign tok_id = fifo_out[IDW:1];
    assign tok_last = fifo_out[0];
    assign busy = state != IDLE;
endmodule

// File: tb/tb_lz77_job_scheduler.sv
// tb_lz77_job_scheduler: directed checks of arbitration, load, token capture, errors and reset
module tb_lz77_job_scheduler;
    logic clk = 1'b0, reset = 1'b1;
    logic [1:0] req = '0, grant, in_valid = '0, in_ready, job_done;
    logic [15:0] in_data = '0;
    logic enc_rst, enc_valid = 1'b0, enc_finish = 1'b0;
    logic [7:0] enc_chardata, enc_char_nxt = '0;
    logic [3:0] enc_offset = '0;
    logic [2:0] enc_match_len = '0;
    logic tok_valid, tok_ready = 1'b1, tok_id, tok_last, busy;
    logic [14:0] tok_data;
    logic err_underrun, err_overflow, err_timeout, err_clr = 1'b0;
    int checks = 0, failures = 0;
    always #5 clk = ~clk;
    lz77_job_scheduler #(.NREQ(2), .IDW(1), .FIFO_DEPTH(8), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .req(req), .grant(grant), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .enc_rst(enc_rst), .enc_chardata(enc_chardata),
        .enc_valid(enc_valid), .enc_finish(enc_finish), .enc_offset(enc_offset),
        .enc_match_len(enc_match_len), .enc_char_nxt(enc_char_nxt), .tok_valid(tok_valid),
        .tok_ready(tok_ready), .tok_data(tok_data), .tok_id(tok_id), .tok_last(tok_last),
        .job_done(job_done), .busy(busy), .err_underrun(err_underrun),
        .err_overflow(err_overflow), .err_timeout(err_timeout), .err_clr(err_clr)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic start(input logic [1:0] rq, input logic [1:0] g, input bit drop_req);
        req = rq;
        @(negedge clk); #1;
        chk("erst_grant", grant, g);
        chk("erst_enc_rst", enc_rst, 1);
        chk("erst_in_ready", in_ready, 0);
        if (drop_req) req = '0;
        @(negedge clk);
    endtask
    task automatic load(input int o, input int gap_at, input int gap_n);
        int n = 0, bad = 0;
        logic [7:0] cd100 = 8'hFF, cdgap = 8'hFF;
        logic [1:0] oh = (o == 0) ? 2'b01 : 2'b10;
        for (int c = 0; c < 3000; c++) begin
            in_valid = (c >= gap_at && c < gap_at + gap_n) ? ~oh : 2'b11;
            in_data = 16'hEEEE;
            if (o == 0) in_data[7:0] = c[7:0];
            else in_data[15:8] = c[7:0];
            enc_valid = (c == 10);
            enc_char_nxt = 8'h24;
            #1;
            if ((in_ready & oh) == 2'b00) break;
            n++;
            if (in_ready !== oh) bad++;
            if (c == 100) cd100 = enc_chardata;
            if (c == gap_at) cdgap = enc_chardata;
            @(negedge clk);
        end
        enc_valid = 1'b0;
        chk("load_len", n, 2048);
        chk("load_other_ready", bad, 0);
        chk("load_chardata", cd100, 8'd100);
        if (gap_n > 0) chk("gap_chardata", cdgap, 8'h00);
        chk("run_enc_rst", enc_rst, 0);
        chk("load_token_ignored", tok_valid, 0);
    endtask
    task automatic tok(input logic [3:0] off, input logic [2:0] len, input logic [7:0] ch);
        enc_offset = off;
        enc_match_len = len;
        enc_char_nxt = ch;
        enc_valid = 1'b1;
        @(negedge clk); #1;
        enc_valid = 1'b0;
    endtask
    task automatic finish_job(input logic [1:0] g);
        enc_finish = 1'b1;
        @(negedge clk); #1;
        enc_finish = 1'b0;
        chk("job_done", job_done, g);
        chk("done_grant", grant, 0);
        chk("done_enc_rst", enc_rst, 1);
        @(negedge clk); #1;
        chk("job_done_once", job_done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_grant", grant, 0);
    endtask
    initial begin
        logic [7:0] kk;
        logic [14:0] exp_tok;
        logic [1:0] done_seen;
        int m;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_enc_rst", enc_rst, 1);
        chk("rst_grant", grant, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_job_done", job_done, 0);
        chk("rst_tok_valid", tok_valid, 0);
        chk("rst_tok_data", tok_data, 0);
        chk("rst_tok_id", tok_id, 0);
        chk("rst_tok_last", tok_last, 0);
        chk("rst_chardata", enc_chardata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_errs", {err_underrun, err_overflow, err_timeout}, 0);
        reset = 1'b0;
        @(negedge clk); #1;
        start(2'b01, 2'b01, 1);
        load(0, 0, 0);
        chk("no_underrun", err_underrun, 0);
        tok(4'h0, 3'h0, 8'h00);
        chk("tok1_valid", tok_valid, 1);
        chk("tok1_data", tok_data, 15'h0000);
        chk("tok1_id", tok_id, 0);
        chk("tok1_last", tok_last, 0);
        tok(4'h3, 3'h2, 8'h24);
        chk("tok2_data", tok_data, 15'h1A24);
        chk("tok2_last", tok_last, 1);
        chk("tok2_id", tok_id, 0);
        @(negedge clk); #1;
        chk("tok_drained", tok_valid, 0);
        finish_job(2'b01);
        start(2'b10, 2'b10, 1);
        load(1, 500, 3);
        chk("underrun_set", err_underrun, 1);
        tok(4'h0, 3'h1, 8'h24);
        chk("u_tok_id", tok_id, 1);
        chk("u_tok_last", tok_last, 1);
        err_clr = 1'b1;
        @(negedge clk); #1;
        err_clr = 1'b0;
        chk("underrun_clr", err_underrun, 0);
        finish_job(2'b10);
        for (int j = 0; j < 3; j++) begin
            start(2'b11, (j % 2 == 0) ? 2'b01 : 2'b10, j == 2);
            load(j % 2, 0, 0);
            tok(4'h1, 3'h1, 8'h24);
            chk("alt_tok_id", tok_id, j % 2);
            finish_job((j % 2 == 0) ? 2'b01 : 2'b10);
        end
        tok_ready = 1'b0;
        start(2'b10, 2'b10, 1);
        load(1, 0, 0);
        for (int k = 0; k < 8; k++) tok(4'(k), 3'(k), 8'(k + 1));
        chk("ovf_not_yet", err_overflow, 0);
        tok(4'h8, 3'h0, 8'h09);
        chk("ovf_set", err_overflow, 1);
        tok(4'h9, 3'h1, 8'h0A);
        chk("ovf_head_valid", tok_valid, 1);
        chk("ovf_head_data", tok_data, 15'h0001);
        finish_job(2'b10);
        tok_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            kk = 8'(k);
            exp_tok = {kk[3:0], kk[2:0], kk + 8'd1};
            chk("drain_data", tok_data, exp_tok);
            chk("drain_id", tok_id, 1);
            @(negedge clk); #1;
        end
        chk("drain_empty", tok_valid, 0);
        chk("no_timeout", err_timeout, 0);
        start(2'b01, 2'b01, 1);
        load(0, 0, 0);
        tok_ready = 1'b0;
        tok(4'h1, 3'h0, 8'h41);
        tok(4'h2, 3'h0, 8'h42);
        m = 3;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (job_done != 2'b00) break;
            m++;
        end
        chk("timeout_run_cycles", m, 64);
        chk("timeout_done", job_done, 2'b01);
        chk("timeout_flag", err_timeout, 1);
        @(negedge clk); #1;
        chk("timeout_idle", busy, 0);
        start(2'b10, 2'b10, 1);
        in_valid = 2'b11;
        repeat (50) @(negedge clk);
        #1;
        chk("pre_rst_load", in_ready, 2'b10);
        chk("pre_rst_fifo", tok_valid, 1);
        reset = 1'b1;
        @(negedge clk); #1;
        chk("mid_rst_enc_rst", enc_rst, 1);
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_tok_valid", tok_valid, 0);
        chk("mid_rst_errs", {err_overflow, err_timeout}, 0);
        reset = 1'b0;
        done_seen = '0;
        repeat (20) begin
            @(negedge clk); #1;
            done_seen |= job_done;
        end
        chk("mid_rst_no_done", done_seen, 0);
        req = 2'b11;
        @(negedge clk); #1;
        chk("rr_ptr_reset", grant, 2'b01);
        req = '0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lz77_job_scheduler.md
Name: lz77_job_scheduler

Overview:
- Shares one LZ77 encoder (2048-char jobs, 4-bit symbols, 10-entry search window, max match 5) among NREQ requesters.
- Grants the encoder round-robin and resets it between jobs.
- Streams the winner's 2048 chars into the encoder during its load phase.
- Collects the encoder's one-cycle token pulses into a backpressured, owner-tagged token FIFO.
- Sits between host DMA channels and the encoder instance.

Parameters:
- NREQ, 2, number of requesters (2..8).
- IDW, 1, width of owner id; must satisfy 2**IDW >= NREQ.
- FIFO_DEPTH, 8, token FIFO entries (power of 2).
- TIMEOUT, 131072, maximum RUN cycles before a job is aborted.

Ports:
- clk  in  1  clock.
- reset  in  1  async active-high reset.
- req  in  NREQ  job request per requester, level.
- grant  out  NREQ  one-hot, current owner.
- in_valid  in  NREQ  char valid per requester.
- in_data  in  8*NREQ  char per requester; slice i = [8i+7:8i].
- in_ready  out  NREQ  char accepted this cycle.
- enc_rst  out  1  encoder reset.
- enc_chardata  out  8  encoder char input.
- enc_valid  in  1  encoder token strobe.
- enc_finish  in  1  encoder finish.
- enc_offset  in  4  encoder offset.
- enc_match_len  in  3  encoder match length.
- enc_char_nxt  in  8  encoder next char.
- tok_valid  out  1  token FIFO head valid.
- tok_ready  in  1  consumer pop.
- tok_data  out  15  {offset[14:11], match_len[10:8], char_nxt[7:0]}.
- tok_id  out  IDW  owner of head token.
- tok_last  out  1  head token is the job terminator.
- job_done  out  NREQ  one-cycle completion pulse.
- busy  out  1  state != IDLE.
- err_underrun  out  1  sticky error flag.
- err_overflow  out  1  sticky error flag.
- err_timeout  out  1  sticky error flag.
- err_clr  in  1  synchronous clear of all err_* flags.

Behaviour:
- Clock clk; reset is asynchronous, active-high.
- Reset values:
  - state=IDLE, enc_rst=1, enc_chardata=0.
  - grant, in_ready, job_done = 0.
  - FIFO empty (tok_valid=0); tok_data, tok_id, tok_last = 0.
  - rr_ptr=0; all err_* flags = 0.
- Reset mid-job: the job is discarded, no job_done pulse, FIFO contents lost.
- IDLE:
  - enc_rst=1.
  - If any req is high, owner = first i at or after rr_ptr (circular) with req[i]=1.
  - rr_ptr <= owner+1 mod NREQ; go to ERST.
- ERST (1 cycle): enc_rst=1, grant[owner]=1.
- LOAD (exactly 2048 cycles, 11-bit load counter):
  - enc_rst=0; in_ready[owner]=1 combinationally; all other in_ready = 0.
  - enc_chardata = in_valid[owner] ? in_data slice of owner : 8'h00.
  - A cycle with in_valid[owner]=0 sets err_underrun; the load does not stall.
  - After count 2047, go to RUN.
- RUN:
  - Waits for enc_finish=1 and moves to DONE.
  - A RUN-cycle counter reaching TIMEOUT sets err_timeout and moves to DONE.
- DONE (1 cycle): job_done[owner]=1, grant=0, enc_rst=1; go to IDLE.
  - job_done does not wait for the FIFO to drain.
- grant[owner] is held from ERST through RUN. req may drop after grant; it is ignored until IDLE.
- Token capture:
  - Active in RUN only; enc_valid in other states is ignored.
  - On enc_valid, push {enc_offset, enc_match_len, enc_char_nxt}, owner, and last = (enc_char_nxt == 8'h24).
  - At most one push per cycle.
- FIFO:
  - First-word fall-through; pop when tok_valid && tok_ready.
  - Push and pop in the same cycle are allowed when full.
  - A push while full with no pop is dropped and sets err_overflow.
  - Pop while empty: no effect.
- err_clr takes priority over a same-cycle set.
- Latency:
  - req at cycle t (IDLE) -> grant at t+1 -> first in_ready at t+2 -> last in_ready at t+2049.
  - enc_valid at cycle u -> tok_valid at u+1 when the FIFO was empty.

Decomposition:
- Package lz77_sched_pkg holds:
  - state enum {IDLE, ERST, LOAD, RUN, DONE}.
  - Width constants OFF_W=4, LEN_W=3, CHR_W=8, TOK_W=15.
  - JOB_LEN=2048, END_CHAR=8'h24.
- Sub-module lz77_tok_fifo:
  - Parameterised width/depth FWFT FIFO.
  - Outputs full/empty and an overflow-drop strobe.
- Round-robin pick stays inline in the scheduler.

Test Plan:
- Job of 2048 x 8'h00 from req[0], tok_ready=1:
  - grant=2'b01 one cycle after req.
  - in_ready[0] high exactly 2048 cycles.
  - First token offset=0, len=0, char=8'h00.
  - Exactly one token with tok_last=1, char=8'h24, tok_id=0.
  - job_done[0] pulses once.
- req=2'b11 held continuously: grants alternate 01, 10, 01.
  - Every tok_id matches the job owner.
  - No ERST begins before the previous DONE.
- in_valid[1] low for 3 cycles mid-load:
  - err_underrun=1 and LOAD length still 2048.
  - err_clr clears it on the next cycle.
- tok_ready=0 for an entire job with FIFO_DEPTH=8:
  - FIFO holds the first 8 tokens; err_overflow=1; job_done still pulses.
- Encoder model never asserts finish, TIMEOUT=64:
  - DONE occurs 64 RUN cycles in; err_timeout=1; returns to IDLE.
- reset asserted during LOAD:
  - Next cycle enc_rst=1, grant=0, in_ready=0, tok_valid=0.
  - No job_done pulse.
